// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, reads the combinational instruction
// memory, and buffers up to two {instr, pc} entries for decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int                   WORD_SIZE  = 16,
  parameter int                   ADDR_BITS  = 8,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = 16'h0000,
  parameter logic [WORD_SIZE-1:0] HALT_INSTR = 16'hB000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  output logic [WORD_SIZE-1:0] o_mem_addr,
  input  logic [WORD_SIZE-1:0] i_mem_data,
  output logic [WORD_SIZE-1:0] o_instr,
  output logic [WORD_SIZE-1:0] o_instr_pc,
  output logic                 o_instr_valid,
  input  logic                 i_instr_ready,
  input  logic                 i_redirect,
  input  logic [WORD_SIZE-1:0] i_redirect_pc,
  output logic                 o_halted
);

  // Memory decodes only the low ADDR_BITS of the address; the PC itself is never truncated.
  if (ADDR_BITS < 1 || ADDR_BITS > WORD_SIZE) begin : g_bad_addr_bits
    $error("fetch_sequencer: ADDR_BITS must lie within 1..WORD_SIZE");
  end

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WORD_SIZE-1:0] r_fetch_pc;
  logic [WORD_SIZE-1:0] w_fetch_pc_next;
  logic [1:0]           r_count;
  logic [1:0]           w_count_next;
  logic [WORD_SIZE-1:0] r_buf_data [0:1];
  logic [WORD_SIZE-1:0] r_buf_pc   [0:1];
  logic [WORD_SIZE-1:0] w_buf_data_next [0:1];
  logic [WORD_SIZE-1:0] w_buf_pc_next   [0:1];

  logic w_pop;
  logic w_push;
  logic w_wr_idx;

  assign w_pop  = o_instr_valid & i_instr_ready;
  assign w_push = (r_state == S_FETCH) & i_run & ((r_count != 2'd2) | w_pop) & ~i_redirect;

  // Slot written by a push: slot 1 when the head stays occupied after this edge, else slot 0.
  assign w_wr_idx = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_pop);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: redirect always wins and also leaves HALTED.
  always_comb begin
    w_state_next = r_state;
    if (i_redirect) begin
      w_state_next = S_FETCH;
    end else if (w_push && (i_mem_data == HALT_INSTR)) begin
      w_state_next = S_HALTED;
    end
  end

  // Output logic
  always_comb begin
    o_instr_valid = (r_count != 2'd0);
    o_halted      = (r_state == S_HALTED) && (r_count == 2'd0);
  end

  // Buffer / PC next-state. Flushed entries keep their contents so instr holds its last value.
  always_comb begin
    w_count_next    = r_count;
    w_fetch_pc_next = r_fetch_pc;
    for (int i = 0; i < 2; i++) begin
      w_buf_data_next[i] = r_buf_data[i];
      w_buf_pc_next[i]   = r_buf_pc[i];
    end
    if (i_redirect) begin
      w_count_next    = 2'd0;
      w_fetch_pc_next = i_redirect_pc;
    end else begin
      if (w_pop && (r_count == 2'd2)) begin
        w_buf_data_next[0] = r_buf_data[1];
        w_buf_pc_next[0]   = r_buf_pc[1];
      end
      if (w_push) begin
        w_buf_data_next[w_wr_idx] = i_mem_data;
        w_buf_pc_next[w_wr_idx]   = r_fetch_pc;
        w_fetch_pc_next           = r_fetch_pc + WORD_SIZE'(1);
      end
      w_count_next = r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_count    <= w_count_next;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= w_buf_data_next[i];
        r_buf_pc[i]   <= w_buf_pc_next[i];
      end
    end
  end

  assign o_mem_addr = r_fetch_pc;
  assign o_instr    = r_buf_data[0];
  assign o_instr_pc = r_buf_pc[0];

endmodule
